// File: rtl/vga_rx_monitor.sv
`default_nettype none
// vga_rx_monitor: VGA link receiver - pixel stream with rebuilt coordinates, line/frame timing checks and lock FSM.
// Optional per-frame checksum is built when VGA_RX_CRC_EN is defined.  Revision 1.0
module vga_rx_monitor #(
  parameter int HTOTAL      = 800,
  parameter int VTOTAL      = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blank_b,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [23:0] pix_rgb,
  output logic        sof,
  output logic        locked,
  output logic        err_hlen,
  output logic        err_vlen,
  output logic [15:0] frame_cnt,
  output logic [15:0] crc_out,
  output logic        crc_valid
);

  typedef enum logic [1:0] {SEARCH = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [15:0] c_HTOTAL  = 16'(HTOTAL);
  localparam logic [15:0] c_VTOTAL  = 16'(VTOTAL);
  localparam logic [15:0] c_TIMEOUT = 16'(2 * VTOTAL);
  localparam logic [7:0]  c_LOCK    = 8'(LOCK_FRAMES);

  state_t      r_state;
  logic        r_hs, r_vs, r_bl, r_hs_d, r_vs_d;
  logic [23:0] r_rgb;
  logic [15:0] r_hcnt, r_lcnt;
  logic [9:0]  r_xcnt, r_ycnt;
  logic        r_line_act, r_sof_pend, r_bad;
  logic [7:0]  r_good;
  logic        r_pix_valid, r_sof, r_locked, r_err_hlen, r_err_vlen;
  logic [9:0]  r_pix_x, r_pix_y;
  logic [23:0] r_pix_rgb;
  logic [15:0] r_frame_cnt;

  logic        w_hfall, w_vfall, w_run, w_act, w_hbad, w_vbad, w_clean;
  logic [15:0] w_lines;
  logic [7:0]  w_good_nx;

  assign w_hfall   = r_hs_d & ~r_hs;
  assign w_vfall   = r_vs_d & ~r_vs;
  assign w_run     = (r_state != SEARCH);
  assign w_act     = w_run & r_bl;
  assign w_hbad    = w_run & w_hfall & ((r_hcnt + 16'd1) != c_HTOTAL);
  // A coincident hsync fall is counted as the frame's last line before the length check.
  assign w_lines   = r_lcnt + {15'd0, w_hfall};
  assign w_vbad    = w_run & w_vfall & (w_lines != c_VTOTAL);
  assign w_clean   = ~r_bad & ~w_hbad & ~w_vbad;
  assign w_good_nx = r_good + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= SEARCH;
      r_hs        <= 1'b0;
      r_vs        <= 1'b0;
      r_bl        <= 1'b0;
      r_hs_d      <= 1'b0;
      r_vs_d      <= 1'b0;
      r_rgb       <= '0;
      r_hcnt      <= '0;
      r_lcnt      <= '0;
      r_xcnt      <= '0;
      r_ycnt      <= '0;
      r_line_act  <= 1'b0;
      r_sof_pend  <= 1'b0;
      r_bad       <= 1'b0;
      r_good      <= '0;
      r_pix_valid <= 1'b0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
      r_pix_rgb   <= '0;
      r_sof       <= 1'b0;
      r_locked    <= 1'b0;
      r_err_hlen  <= 1'b0;
      r_err_vlen  <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_hs   <= hsync;
      r_vs   <= vsync;
      r_bl   <= blank_b;
      r_rgb  <= {r, g, b};
      r_hs_d <= r_hs;
      r_vs_d <= r_vs;

      if (w_hfall)                r_hcnt <= '0;
      else if (r_hcnt != 16'hFFFF) r_hcnt <= r_hcnt + 16'd1;

      if (w_vfall)                            r_lcnt <= '0;
      else if (w_hfall && r_lcnt != 16'hFFFF) r_lcnt <= r_lcnt + 16'd1;

      if (w_hbad) r_err_hlen <= 1'b1;
      if (w_vbad) r_err_vlen <= 1'b1;

      if (w_vfall)     r_bad <= 1'b0;
      else if (w_hbad) r_bad <= 1'b1;

      case (r_state)
        SEARCH: if (w_vfall) begin
          r_state <= ACQUIRE;
          r_good  <= '0;
        end
        ACQUIRE: if (w_vfall) begin
          if (!w_clean) begin
            r_good <= '0;
          end else begin
            r_good <= w_good_nx;
            if (w_good_nx == c_LOCK) begin
              r_state  <= LOCKED;
              r_locked <= 1'b1;
            end
          end
        end
        LOCKED: if ((w_vfall && !w_clean) || (!w_vfall && r_lcnt >= c_TIMEOUT)) begin
          r_state  <= ACQUIRE;
          r_locked <= 1'b0;
          r_good   <= '0;
        end
        default: r_state <= SEARCH;
      endcase

      if (w_vfall && w_run) r_frame_cnt <= r_frame_cnt + 16'd1;

      r_pix_valid <= w_act;
      r_sof       <= w_act & r_sof_pend;
      if (w_act) begin
        r_pix_x   <= r_xcnt;
        r_pix_y   <= r_ycnt;
        r_pix_rgb <= r_rgb;
      end

      if (w_vfall)     r_sof_pend <= 1'b1;
      else if (w_act)  r_sof_pend <= 1'b0;

      // A pixel coincident with the hsync fall still belongs to the line that is ending.
      if (w_hfall)                        r_xcnt <= '0;
      else if (w_act && r_xcnt != 10'h3FF) r_xcnt <= r_xcnt + 10'd1;

      if (w_vfall) begin
        r_ycnt     <= '0;
        r_line_act <= 1'b0;
      end else if (w_hfall) begin
        if ((r_line_act || w_act) && (r_ycnt != 10'h3FF)) r_ycnt <= r_ycnt + 10'd1;
        r_line_act <= 1'b0;
      end else if (w_act) begin
        r_line_act <= 1'b1;
      end
    end
  end

`ifdef VGA_RX_CRC_EN
  logic [15:0] r_crc, r_crc_out;
  logic        r_crc_valid;
  logic [15:0] w_crc_base, w_crc_nx;

  assign w_crc_base = r_sof_pend ? 16'h0000 : r_crc;
  assign w_crc_nx   = {w_crc_base[14:0], w_crc_base[15]} ^ {8'h00, r_rgb[23:16]} ^ r_rgb[15:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_crc       <= '0;
      r_crc_out   <= '0;
      r_crc_valid <= 1'b0;
    end else begin
      r_crc_valid <= w_vfall & w_run;
      if (w_act) r_crc <= w_crc_nx;
      if (w_vfall && w_run) r_crc_out <= w_act ? w_crc_nx : r_crc;
    end
  end

  assign crc_out   = r_crc_out;
  assign crc_valid = r_crc_valid;
`else
  assign crc_out   = 16'h0000;
  assign crc_valid = 1'b0;
`endif

  assign pix_valid = r_pix_valid;
  assign pix_x     = r_pix_x;
  assign pix_y     = r_pix_y;
  assign pix_rgb   = r_pix_rgb;
  assign sof       = r_sof;
  assign locked    = r_locked;
  assign err_hlen  = r_err_hlen;
  assign err_vlen  = r_err_vlen;
  assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vga_rx_monitor.sv
`default_nettype none
// tb_vga_rx_monitor: randomized VGA source with a line-level reference model and pixel/checksum scoreboards.
module tb_vga_rx_monitor;

  localparam int HT = 40;
  localparam int VT = 12;
  localparam int LF = 2;
  localparam int AH = 24;
  localparam int AV = 8;
  localparam int X0 = 8;
  localparam int HSW = 4;
  localparam int S_SEARCH = 0, S_ACQ = 1, S_LOCK = 2;

  logic clk = 1'b0, reset = 1'b1;
  logic hsync = 1'b1, vsync = 1'b1, blank_b = 1'b0;
  logic [7:0] r = 8'h00, g = 8'h00, b = 8'h00;
  logic pix_valid, sof, locked, err_hlen, err_vlen, crc_valid;
  logic [9:0] pix_x, pix_y;
  logic [23:0] pix_rgb;
  logic [15:0] frame_cnt, crc_out;

  vga_rx_monitor #(.HTOTAL(HT), .VTOTAL(VT), .LOCK_FRAMES(LF)) dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .blank_b(blank_b),
    .r(r), .g(g), .b(b), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_rgb(pix_rgb), .sof(sof), .locked(locked), .err_hlen(err_hlen),
    .err_vlen(err_vlen), .frame_cnt(frame_cnt), .crc_out(crc_out), .crc_valid(crc_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] rgb;
    logic        sof;
    logic [31:0] t;
  } pix_t;

  pix_t        exp_q[$];
  logic [15:0] crc_q[$];
  int n_checks = 0, n_fail = 0;

  // Reference model state, advanced once per line start and once per emitted pixel.
  bit          m_in_rst = 1'b1;
  int          m_state, m_good, m_lines, m_y, m_prev_len;
  bit          m_prev_vs = 1'b1, m_bad, m_sof, m_line_act, m_locked, m_err_h, m_err_v;
  logic [15:0] m_fcnt, m_crc, m_crc_last;
  bit          const_px = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset(input bit vs_now);
    m_in_rst = 1'b0; m_state = S_SEARCH; m_good = 0; m_lines = 0; m_y = 0;
    m_prev_len = HT; m_prev_vs = vs_now; m_bad = 0; m_sof = 0; m_line_act = 0;
    m_locked = 0; m_err_h = 0; m_err_v = 0; m_fcnt = 0; m_crc = 0; m_crc_last = 0;
  endtask

  task automatic model_line_start(input bit vf);
    bit run;
    run = (m_state != S_SEARCH);
    if (run && m_prev_len != HT) begin m_err_h = 1; m_bad = 1; end
    m_lines++;
    if (m_line_act) m_y++;
    m_line_act = 0;
    if (vf) begin
      if (run) begin
        if (m_lines != VT) begin m_err_v = 1; m_bad = 1; end
        m_fcnt++;
`ifdef VGA_RX_CRC_EN
        crc_q.push_back(m_crc);
        m_crc_last = m_crc;
`endif
        if (m_bad) begin
          m_good = 0;
          if (m_state == S_LOCK) begin m_state = S_ACQ; m_locked = 0; end
        end else if (m_state == S_ACQ) begin
          m_good++;
          if (m_good == LF) begin m_state = S_LOCK; m_locked = 1; end
        end
      end else begin
        m_state = S_ACQ; m_good = 0;
      end
      m_lines = 0; m_bad = 0; m_y = 0; m_sof = 1; m_crc = 0;
    end else if (m_state == S_LOCK && m_lines >= 2 * VT) begin
      m_state = S_ACQ; m_good = 0; m_locked = 0;
    end
  endtask

  // One line: hsync low for HSW clocks at its start, vsync level held for the line, optional active span.
  task automatic drive_line(input int len, input bit vs_lo, input bit act, input int rel_at);
    bit   vf;
    pix_t e;
    vf = vs_lo && m_prev_vs;
    if (!m_in_rst) model_line_start(vf);
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      if (c == rel_at) begin
        reset = 1'b0;
        model_reset(!vs_lo);
      end
      hsync = (c >= HSW);
      vsync = !vs_lo;
      if (act && c >= X0 && c < X0 + AH) begin
        blank_b = 1'b1;
        if (const_px) {r, g, b} = 24'hFF0000;
        else          {r, g, b} = 24'($urandom);
        if (!m_in_rst && m_state != S_SEARCH) begin
          e.x = 10'(c - X0); e.y = 10'(m_y); e.rgb = {r, g, b}; e.sof = m_sof; e.t = 32'(cyc + 2);
          exp_q.push_back(e);
          m_sof = 0; m_line_act = 1;
          m_crc = {m_crc[14:0], m_crc[15]} ^ {8'h00, r} ^ {g, b};
        end
      end else begin
        blank_b = 1'b0;
        {r, g, b} = 24'h0;
      end
      if (c == HT / 2) begin
        if (m_in_rst) begin
          chk("rst_pix", {12'h0, pix_valid, sof, pix_x, pix_y}, 32'h0);
          chk("rst_rgb", {8'h0, pix_rgb}, 32'h0);
          chk("rst_status", {12'h0, locked, err_hlen, err_vlen, crc_valid, frame_cnt}, 32'h0);
          chk("rst_crc", {16'h0, crc_out}, 32'h0);
        end else begin
          chk("locked", {31'h0, locked}, {31'h0, m_locked});
          chk("err_hlen", {31'h0, err_hlen}, {31'h0, m_err_h});
          chk("err_vlen", {31'h0, err_vlen}, {31'h0, m_err_v});
          chk("frame_cnt", {16'h0, frame_cnt}, {16'h0, m_fcnt});
          chk("crc_out", {16'h0, crc_out}, {16'h0, m_crc_last});
        end
      end
    end
    m_prev_len = len;
    m_prev_vs  = !vs_lo;
  endtask

  task automatic drive_frame(input int nlines, input int long_idx, input int first);
    for (int l = first; l < nlines; l++)
      drive_line((l == long_idx) ? HT + 1 : HT, l < 2, (l >= 2) && (l < 2 + AV), -1);
  endtask

  // Pixel and checksum monitor, independent of the stimulus process.
  initial begin
    pix_t        e;
    logic [15:0] ec;
    forever begin
      @(negedge clk);
      if (pix_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL pix_unexpected: got x=%0d y=%0d rgb=%06h expected no pixel", pix_x, pix_y, pix_rgb);
        end else begin
          e = exp_q.pop_front();
          if ({pix_x, pix_y, pix_rgb, sof} !== {e.x, e.y, e.rgb, e.sof} || cyc != int'(e.t)) begin
            n_fail++;
            $display("FAIL pix: got x=%0d y=%0d rgb=%06h sof=%0b cyc=%0d expected x=%0d y=%0d rgb=%06h sof=%0b cyc=%0d",
                     pix_x, pix_y, pix_rgb, sof, cyc, e.x, e.y, e.rgb, e.sof, e.t);
          end
        end
      end else if (sof) begin
        n_checks++; n_fail++;
        $display("FAIL sof_without_pixel: got sof=1 expected 0");
      end
      if (crc_valid) begin
        n_checks++;
        if (crc_q.size() == 0) begin
          n_fail++;
          $display("FAIL crc_unexpected: got crc_valid=1 crc=%04h expected no pulse", crc_out);
        end else begin
          ec = crc_q.pop_front();
          if (crc_out !== ec) begin
            n_fail++;
            $display("FAIL crc: got %04h expected %04h", crc_out, ec);
          end
        end
      end
    end
  end

  initial begin
    int sel;
    // Reset held while syncs toggle (including a vsync fall), then released mid-line.
    drive_line(HT, 0, 1, -1);
    drive_line(HT, 1, 1, -1);
    drive_line(HT, 0, 1, 15);
    for (int i = 0; i < 3; i++) drive_line(HT, 0, 1, -1);

    drive_frame(VT, -1, 0);
    drive_frame(VT, -1, 0);
    chk("not_locked_after_1", {31'h0, locked}, 32'h0);
    drive_frame(VT, -1, 0);
    chk("locked_after_2", {31'h0, locked}, 32'h1);
    drive_line(HT, 1, 0, -1);
    chk("frame_cnt_3", {16'h0, frame_cnt}, 32'd3);
    chk("no_err_clean", {30'h0, err_hlen, err_vlen}, 32'h0);
    drive_frame(VT, -1, 1);

    drive_frame(VT, 5, 0);
    drive_line(HT, 1, 0, -1);
    chk("err_hlen_set", {31'h0, err_hlen}, 32'h1);
    chk("unlock_on_hlen", {31'h0, locked}, 32'h0);
    drive_frame(VT, -1, 1);
    drive_frame(VT, -1, 0);
    drive_frame(VT, -1, 0);
    chk("relock_hlen", {31'h0, locked}, 32'h1);
    chk("err_hlen_sticky", {31'h0, err_hlen}, 32'h1);

    drive_frame(VT - 1, -1, 0);
    drive_line(HT, 1, 0, -1);
    chk("err_vlen_set", {31'h0, err_vlen}, 32'h1);
    drive_frame(VT, -1, 1);
    drive_frame(VT, -1, 0);
    drive_frame(VT, -1, 0);
    chk("relock_vlen", {31'h0, locked}, 32'h1);

    for (int l = 0; l < 2 * VT + 2; l++)
      drive_line(HT, 0, ((l % VT) >= 2) && ((l % VT) < 2 + AV), -1);
    chk("unlock_timeout", {31'h0, locked}, 32'h0);

    for (int f = 0; f < 8; f++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        2:       drive_frame(VT, int'($urandom_range(0, VT - 1)), 0);
        3:       drive_frame(($urandom_range(0, 1) != 0) ? VT + 1 : VT - 1, -1, 0);
        default: drive_frame(VT, -1, 0);
      endcase
    end

    for (int f = 0; f < 3; f++) drive_frame(VT, -1, 0);
    const_px = 1'b1;
    for (int f = 0; f < 3; f++) drive_frame(VT, -1, 0);
    const_px = 1'b0;
    drive_frame(3, -1, 0);
    chk("locked_final", {31'h0, locked}, 32'h1);
    repeat (10) @(negedge clk);
    chk("pix_queue_empty", 32'(exp_q.size()), 32'h0);
    chk("crc_queue_empty", 32'(crc_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
